// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DefaultXlen  = 32;
  localparam int unsigned DefaultNregs = 32;

  typedef enum logic {
    StClear,
    StReady
  } rf_state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array select, write forwarding and zero masking.
module regfile_read_port #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic [XLEN-1:0] regs_i [NREGS],
  input  logic [AW-1:0]   raddr_i,
  input  logic            ready_i,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  always_comb begin
    rdata_o = regs_i[raddr_i];
    // wr_en_i is already qualified, so forwarding never exposes a dropped write
    if (BYPASS != 0 && wr_en_i && raddr_i == waddr_i) begin
      rdata_o = wdata_i;
    end
    if (!ready_i || (ZERO_R0 != 0 && raddr_i == '0)) begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/multiport_regfile.sv
// Register file with NREAD combinational read ports, one write port and a post-reset clear walk.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN    = DefaultXlen,
  parameter int unsigned NREGS   = DefaultNregs,
  parameter int unsigned NREAD   = 2,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   io_raddr,
  output logic [NREAD*XLEN-1:0] io_rdata,
  input  logic [AW-1:0]         io_rd,
  input  logic [XLEN-1:0]       io_wdata,
  input  logic                  io_regwrite,
  output logic                  io_ready
);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign io_ready = (state_q == StReady);
  assign wr_en    = io_regwrite && io_ready && (ZERO_R0 == 0 || io_rd != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StClear: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d = StReady;
        end
      end
      StReady: state_d = StReady;
      default: state_d = StClear;
    endcase
  end

  // Storage has no reset; the clear walk is the only thing that zeroes it.
  always_ff @(posedge clock) begin
    if (state_q == StClear) begin
      regs_q[clr_idx_q] <= '0;
    end else if (wr_en) begin
      regs_q[io_rd] <= io_wdata;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_read_port #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .BYPASS (BYPASS),
      .ZERO_R0(ZERO_R0)
    ) u_rd (
      .regs_i (regs_q),
      .raddr_i(io_raddr[k*AW +: AW]),
      .ready_i(io_ready),
      .wr_en_i(wr_en),
      .waddr_i(io_rd),
      .wdata_i(io_wdata),
      .rdata_o(io_rdata[k*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Scoreboard bench: one forwarding/zero-r0 instance and one plain instance share stimulus.
module tb_multiport_regfile;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NREAD = 2;
  localparam int unsigned AW    = 5;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREAD*AW-1:0]   io_raddr;
  logic [AW-1:0]         io_rd;
  logic [XLEN-1:0]       io_wdata;
  logic                  io_regwrite;
  logic [NREAD*XLEN-1:0] rdata_a, rdata_b;
  logic                  ready_a, ready_b;

  always #5 clock = ~clock;

  multiport_regfile #(
    .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1), .ZERO_R0(1)
  ) dut_a (
    .clock(clock), .reset(reset), .io_raddr(io_raddr), .io_rdata(rdata_a),
    .io_rd(io_rd), .io_wdata(io_wdata), .io_regwrite(io_regwrite), .io_ready(ready_a)
  );

  multiport_regfile #(
    .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0), .ZERO_R0(0)
  ) dut_b (
    .clock(clock), .reset(reset), .io_raddr(io_raddr), .io_rdata(rdata_b),
    .io_rd(io_rd), .io_wdata(io_wdata), .io_regwrite(io_regwrite), .io_ready(ready_b)
  );

  typedef struct {
    string           tag;
    logic            ready;
    logic [XLEN-1:0] a0, a1, b0, b1;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: visible register contents once the file is ready.
  logic [XLEN-1:0] mem_a [NREGS];
  logic [XLEN-1:0] mem_b [NREGS];
  bit              m_ready;
  int              clr_cnt;

  function automatic logic [XLEN-1:0] exp_a(input logic [AW-1:0] a);
    if (!m_ready || a == '0) return '0;
    if (io_regwrite && a == io_rd) return io_wdata;
    return mem_a[a];
  endfunction

  function automatic logic [XLEN-1:0] exp_b(input logic [AW-1:0] a);
    if (!m_ready) return '0;
    return mem_b[a];
  endfunction

  task automatic chk(input string tag, input string what,
                     input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s %s: got %h want %h", tag, what, act, want);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, "ready_a", {31'b0, ready_a}, {31'b0, e.ready});
      chk(e.tag, "ready_b", {31'b0, ready_b}, {31'b0, e.ready});
      chk(e.tag, "a.rdata0", rdata_a[0 +: XLEN], e.a0);
      chk(e.tag, "a.rdata1", rdata_a[XLEN +: XLEN], e.a1);
      chk(e.tag, "b.rdata0", rdata_b[0 +: XLEN], e.b0);
      chk(e.tag, "b.rdata1", rdata_b[XLEN +: XLEN], e.b1);
    end
  end

  // Apply one cycle of stimulus, queue its expectation, then advance the model past the edge.
  task automatic step(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                      input logic [AW-1:0] rd, input logic [XLEN-1:0] wd,
                      input logic we, input string tag);
    exp_t e;
    io_raddr    = {ra1, ra0};
    io_rd       = rd;
    io_wdata    = wd;
    io_regwrite = we;
    if (reset) begin
      m_ready = 1'b0;
      clr_cnt = 0;
    end
    e.tag   = tag;
    e.ready = m_ready;
    e.a0    = exp_a(ra0);
    e.a1    = exp_a(ra1);
    e.b0    = exp_b(ra0);
    e.b1    = exp_b(ra1);
    sb_q.push_back(e);
    @(posedge clock);
    if (!reset) begin
      if (m_ready && we) begin
        if (rd != '0) mem_a[rd] = wd;
        mem_b[rd] = wd;
      end
      if (!m_ready) begin
        clr_cnt++;
        if (clr_cnt == NREGS) begin
          m_ready = 1'b1;
          for (int i = 0; i < NREGS; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
          end
        end
      end
    end
    #1;
  endtask

  function automatic logic [AW-1:0] raddr_rand();
    return AW'($urandom_range(NREGS - 1, 0));
  endfunction

  initial begin
    reset       = 1'b1;
    io_raddr    = '0;
    io_rd       = '0;
    io_wdata    = '0;
    io_regwrite = 1'b0;
    m_ready     = 1'b0;
    clr_cnt     = 0;
    @(posedge clock);
    #1;
    step(raddr_rand(), raddr_rand(), 5'd1, 32'h1, 1'b1, "in_reset");
    step(raddr_rand(), raddr_rand(), 5'd2, 32'h2, 1'b1, "in_reset");
    reset = 1'b0;

    // Clear walk: ready low for NREGS cycles, write at cycle 10 must be dropped.
    for (int i = 0; i < 34; i++) begin
      step(raddr_rand(), 5'd3, 5'd3, 32'hAA, i == 10, "clear");
    end

    step(5'd3, 5'd3, 5'd0, 32'h0, 1'b0, "reg3_dropped");
    step(5'd1, 5'd2, 5'd5, 32'hDEADBEEF, 1'b1, "wr5");
    step(5'd5, 5'd5, 5'd0, 32'h0, 1'b0, "rd5_both");
    step(5'd7, 5'd5, 5'd7, 32'h12345678, 1'b1, "bypass7");
    step(5'd7, 5'd7, 5'd0, 32'h0, 1'b0, "rd7_next");
    step(5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, "wr_r0");
    step(5'd0, 5'd7, 5'd0, 32'h0, 1'b0, "rd_r0_next");

    for (int i = 0; i < 300; i++) begin
      step(AW'($urandom_range(7, 0)), raddr_rand(), AW'($urandom_range(7, 0)),
           $urandom(), 1'($urandom_range(1, 0)), "rand");
    end

    // Reset mid-operation restarts the clear and wipes register 9.
    step(5'd9, 5'd9, 5'd9, 32'h55, 1'b1, "wr9");
    step(5'd9, 5'd9, 5'd0, 32'h0, 1'b0, "rd9");
    reset = 1'b1;
    step(5'd9, 5'd9, 5'd9, 32'h66, 1'b1, "mid_reset");
    reset = 1'b0;
    for (int i = 0; i < 33; i++) begin
      step(5'd9, raddr_rand(), 5'd9, $urandom(), i < 32, "reclear");
    end
    step(5'd9, 5'd9, 5'd0, 32'h0, 1'b0, "rd9_after");

    for (int i = 0; i < 100; i++) begin
      step(raddr_rand(), raddr_rand(), raddr_rand(), $urandom(),
           1'($urandom_range(1, 0)), "rand2");
    end

    @(negedge clock);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
